// File: rtl/mips_regfile_sb.sv
// MIPS register file: 2 async read ports, 1 sync write port, hardwired $zero,
// post-reset clear sequence and per-register busy scoreboard. Optional REGFILE_BYPASS_EN.
module mips_regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int ZERO_REG = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_reg_1,
  input  logic [ADDR_W-1:0] read_reg_2,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  output logic              read_busy_1,
  output logic              read_busy_2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              signal_reg_write,
  input  logic [ADDR_W-1:0] reserve_reg,
  input  logic              signal_reserve,
  output logic              ready
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                   state, state_nxt;
  logic [ADDR_W-1:0]        clear_ptr;
  logic [DATA_W-1:0]        regs [DEPTH];
  logic [DEPTH-1:0]         busy;
  logic                     wr_en, rsv_en;
  logic [1:0][ADDR_W-1:0]   rd_idx;
  logic [1:0][DATA_W-1:0]   rd_val;
  logic [1:0]               rd_bsy;

  assign ready = (state == READY);

  // $zero swallows both writes and reservations
  assign wr_en  = ready && signal_reg_write && !((ZERO_REG != 0) && (write_reg == '0));
  assign rsv_en = ready && signal_reserve && !((ZERO_REG != 0) && (reserve_reg == '0));

  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && clear_ptr == '1) state_nxt = READY;
  end

  always_ff @(posedge clk) begin
    if (rst)                 clear_ptr <= '0;
    else if (state == CLEAR) clear_ptr <= clear_ptr + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) regs[clear_ptr] <= INIT_VAL;
      else if (wr_en)     regs[write_reg] <= write_data;
    end
  end

  // Reserve applied after write-back clear so a same-cycle new producer wins
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else begin
      if (wr_en)  busy[write_reg]   <= 1'b0;
      if (rsv_en) busy[reserve_reg] <= 1'b1;
    end
  end

  assign rd_idx = {read_reg_2, read_reg_1};

  always_comb begin
    rd_val = '0;
    rd_bsy = '0;
    for (int p = 0; p < 2; p++) begin
      if (ready && !((ZERO_REG != 0) && (rd_idx[p] == '0))) begin
        rd_val[p] = regs[rd_idx[p]];
        rd_bsy[p] = busy[rd_idx[p]];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && write_reg == rd_idx[p]) begin
          rd_val[p] = write_data;
          rd_bsy[p] = rsv_en && (reserve_reg == rd_idx[p]);
        end
`endif
      end
    end
  end

  assign read_data_1 = rd_val[0];
  assign read_data_2 = rd_val[1];
  assign read_busy_1 = rd_bsy[0];
  assign read_busy_2 = rd_bsy[1];
endmodule
